// File: rtl/lsu.sv
// Load/store unit: one byte/half/word access per op over a req/gnt/rvalid
// memory handshake, with load alignment/extension and a grant/read timeout.
module lsu #(
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [DATA_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_LEN-1:0] mem_addr,
  output logic [3:0]          mem_wstrb,
  output logic [DATA_LEN-1:0] mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [DATA_LEN-1:0]   addr_q;
  logic [DATA_LEN-1:0]   wdata_q;
  logic [3:0]            wstrb_q;
  logic [DATA_LEN-1:0]   rdata_q;
  logic                  err_q;
  logic [CW-1:0]         cnt_q;

  logic                  illegal, misaligned, bad_op, tmo;
  logic [3:0]            lane_strb;
  logic [DATA_LEN-1:0]   lane_data;
  logic [DATA_LEN-1:0]   shifted, load_data;

  // Classify the incoming op as illegal or misaligned.
  always_comb begin
    illegal    = req_we ? (req_funct3 > 3'b010)
                        : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    bad_op = illegal | misaligned;
  end

  // Byte strobes and lane-replicated store data.
  always_comb begin
    lane_strb = '0;
    lane_data = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          lane_strb = 4'b0001 << req_addr[1:0];
          lane_data = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          lane_strb = 4'b0011 << req_addr[1:0];
          lane_data = {2{req_wdata[15:0]}};
        end
        default: begin
          lane_strb = 4'b1111;
          lane_data = req_wdata;
        end
      endcase
    end
  end

  // Align the returned word and sign/zero-extend per funct3.
  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  assign tmo = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a grant or rvalid in the final counted cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = bad_op ? RESP : REQ;
      REQ: begin
        if (mem_gnt)  state_d = we_q ? RESP : WAIT_R;
        else if (tmo) state_d = RESP;
      end
      WAIT_R: begin
        if (mem_rvalid) state_d = RESP;
        else if (tmo)   state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields, response data/error and the timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= lane_data;
            wstrb_q  <= lane_strb;
            rdata_q  <= '0;
            err_q    <= bad_op;
            cnt_q    <= '0;
          end
        end
        REQ: begin
          if (mem_gnt)  cnt_q <= '0;
          else if (tmo) err_q <= 1'b1;
          else          cnt_q <= cnt_q + CW'(1);
        end
        WAIT_R: begin
          if (mem_rvalid) rdata_q <= load_data;
          else if (tmo)   err_q   <= 1'b1;
          else            cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) & err_q;
  assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign mem_req    = (state_q == REQ);
  assign mem_we     = (state_q == REQ) & we_q;
  assign mem_addr   = (state_q == REQ) ? {addr_q[DATA_LEN-1:2], 2'b00} : '0;
  assign mem_wstrb  = (state_q == REQ) ? wstrb_q : '0;
  assign mem_wdata  = (state_q == REQ) ? wdata_q : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu, built with a 4-cycle timeout.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks   = 0;
  int failures = 0;

  lsu #(.DATA_LEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if ({busy, resp_valid, resp_err, mem_req, mem_we} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {busy, resp_valid, resp_err, mem_req, mem_we}); end
    checks++; if ({resp_rdata, mem_addr, mem_wdata, mem_wstrb} !== '0) begin failures++; $display("FAIL rst_buses got=%h exp=0", {resp_rdata, mem_addr, mem_wdata, mem_wstrb}); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_load_lb;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0000_1003;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL lb_accept_ready got=%b exp=1", req_ready); end
    tick;  // cycle 1
    req_valid = 1'b0; mem_gnt = 1'b1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL lb_mem_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_1000) begin failures++; $display("FAIL lb_mem_addr got=%h exp=00001000", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL lb_mem_we got=%b exp=0", mem_we); end
    tick;  // cycle 2
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    checks++; if ({mem_req, resp_valid} !== 2'b00) begin failures++; $display("FAIL lb_wait got=%b exp=00", {mem_req, resp_valid}); end
    tick;  // cycle 3
    mem_rvalid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL lb_resp_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL lb_err got=%b exp=0", resp_err); end
    tick;  // cycle 4
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL lb_after got=%b exp=01", {resp_valid, req_ready}); end
  endtask

  task automatic test_store_sh_stall;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0000_2002; req_wdata = 32'h1234_ABCD;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      checks++; if ({mem_req, mem_we, resp_valid} !== 3'b110) begin failures++; $display("FAIL sh_req_c%0d got=%b exp=110", i, {mem_req, mem_we, resp_valid}); end
      checks++; if (mem_addr !== 32'h0000_2000 || mem_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_addr_strb_c%0d got=%h/%b exp=00002000/1100", i, mem_addr, mem_wstrb); end
      checks++; if (mem_wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata_c%0d got=%h exp=abcdabcd", i, mem_wdata); end
      tick;
    end
    mem_gnt = 1'b0;
    checks++; if ({resp_valid, resp_err, mem_req} !== 3'b100) begin failures++; $display("FAIL sh_resp got=%b exp=100", {resp_valid, resp_err, mem_req}); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL sh_rdata got=%h exp=0", resp_rdata); end
    tick;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL sh_single_pulse got=%b exp=0", resp_valid); end
  endtask

  task automatic test_bad_ops;
    logic        t_we[3]     = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  t_funct3[3] = '{3'b010, 3'b001, 3'b111};
    logic [31:0] t_addr[3]   = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_we = t_we[i]; req_funct3 = t_funct3[i]; req_addr = t_addr[i]; req_wdata = 32'h5555_AAAA;
      tick;
      req_valid = 1'b0;
      checks++; if ({mem_req, resp_valid, resp_err} !== 3'b011) begin failures++; $display("FAIL bad%0d_resp got=%b exp=011", i, {mem_req, resp_valid, resp_err}); end
      checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL bad%0d_rdata got=%h exp=0", i, resp_rdata); end
      tick;
      checks++; if ({resp_valid, req_ready, mem_req} !== 3'b010) begin failures++; $display("FAIL bad%0d_after got=%b exp=010", i, {resp_valid, req_ready, mem_req}); end
    end
  endtask

  task automatic test_half_extend;
    logic [2:0]  t_funct3[2] = '{3'b101, 3'b001};
    logic [31:0] t_exp[2]    = '{32'h0000_F00D, 32'hFFFF_F00D};
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = t_funct3[i]; req_addr = 32'h0000_0002;
      tick;
      req_valid = 1'b0; mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hF00D_0000;
      tick;
      mem_rvalid = 1'b0;
      checks++; if ({resp_valid, resp_err} !== 2'b10) begin failures++; $display("FAIL half%0d_resp got=%b exp=10", i, {resp_valid, resp_err}); end
      checks++; if (resp_rdata !== t_exp[i]) begin failures++; $display("FAIL half%0d_rdata got=%h exp=%h", i, resp_rdata, t_exp[i]); end
      tick;
    end
  endtask

  task automatic test_timeout;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_3000;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_req, resp_valid} !== 2'b10) begin failures++; $display("FAIL tmo_req_c%0d got=%b exp=10", i, {mem_req, resp_valid}); end
      tick;
    end
    checks++; if ({mem_req, resp_valid, resp_err} !== 3'b011) begin failures++; $display("FAIL tmo_resp got=%b exp=011", {mem_req, resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL tmo_rdata got=%h exp=0", resp_rdata); end
    tick;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_idle_busy got=%b exp=0", busy); end
    tick;
    mem_rvalid = 1'b0;
    checks++; if ({resp_valid, busy, req_ready} !== 3'b001) begin failures++; $display("FAIL tmo_stray_rvalid got=%b exp=001", {resp_valid, busy, req_ready}); end
    tick;
    checks++; if ({resp_valid, busy} !== 2'b00) begin failures++; $display("FAIL tmo_stray_later got=%b exp=00", {resp_valid, busy}); end
  endtask

  task automatic test_reset_mid_access;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_4000;
    tick;
    req_valid = 1'b0; mem_gnt = 1'b1;
    tick;  // WAIT_R
    mem_gnt = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, req_ready, resp_valid, mem_req} !== 4'b0100) begin failures++; $display("FAIL mid_reset got=%b exp=0100", {busy, req_ready, resp_valid, mem_req}); end
    rst_n = 1'b1;
    tick;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h0000_4001;
    tick;
    req_valid = 1'b0; mem_gnt = 1'b1;
    checks++; if (mem_addr !== 32'h0000_4000) begin failures++; $display("FAIL post_rst_addr got=%h exp=00004000", mem_addr); end
    tick;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_AB00;
    tick;
    mem_rvalid = 1'b0;
    checks++; if ({resp_valid, resp_err} !== 2'b10) begin failures++; $display("FAIL post_rst_resp got=%b exp=10", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'h0000_00AB) begin failures++; $display("FAIL post_rst_rdata got=%h exp=000000ab", resp_rdata); end
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset;
    test_load_lb;
    test_store_sh_stall;
    test_bad_ops;
    test_half_extend;
    test_timeout;
    test_reset_mid_access;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address plus the rs2 store data, and performs one byte/half/word access to data memory over a req/gnt/rvalid handshake. Loads are aligned and sign- or zero-extended before they return to writeback. The core stalls on busy while an access is in flight.

Parameters:
DATA_LEN, 32, data/address width (matches ALU data width; only 32 supported)
TIMEOUT, 256, cycles waited in REQ or WAIT_R before aborting with err; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
req_addr  in  DATA_LEN  effective address (ALU result)
req_wdata  in  DATA_LEN  store data (rs2)
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  DATA_LEN  extended load data (0 for stores/errors)
resp_err  out  1  valid with resp_valid: misaligned, illegal funct3 or timeout
busy  out  1  state != IDLE (core stall)
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  DATA_LEN  word address, {req_addr[31:2],2'b00}
mem_wstrb  out  4  byte strobes
mem_wdata  out  DATA_LEN  store data replicated into lanes
mem_gnt  in  1  memory accepted the request
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_LEN  read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0 except req_ready=1. Takes effect immediately, including mid-access. An outstanding memory transaction is dropped, and a later mem_rvalid in IDLE is ignored.
- States: IDLE, REQ, WAIT_R, RESP. All outputs are registered or decoded from state and registered fields only.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata.
  - If the op is illegal or misaligned, go to RESP with err=1 and no memory access.
  - Otherwise go to REQ.
- Illegal: load funct3 in {011,110,111}; store funct3 > 010.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- REQ: mem_req=1 with stable addr/we/wstrb/wdata until mem_gnt. On gnt, a store goes to RESP and a load goes to WAIT_R.
- WAIT_R: on mem_rvalid, capture the extracted data and go to RESP. mem_rvalid is honoured only in WAIT_R, i.e. no earlier than the cycle after gnt.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready stays 0 in RESP, so back-to-back ops are spaced by one cycle.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wstrb=0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: wstrb=1111.
- Load extract:
  - byte = mem_rdata >> (8*addr[1:0]); half = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Timeout counter: cleared on entry to REQ and to WAIT_R, incremented each cycle in those states. When it reaches TIMEOUT (and TIMEOUT != 0), go to RESP with err=1 and rdata=0, and drop mem_req.
- Min latency, counting the accept cycle as 0:
  - Store with gnt in cycle 1: resp_valid in cycle 2.
  - Load with gnt in cycle 1 and rvalid in cycle 2: resp_valid in cycle 3.
- busy = (state != IDLE); req_ready = (state == IDLE).

Test Plan:
1. LB addr=0x1003, mem_rdata=0x80FF_1234, gnt in cycle 1, rvalid in cycle 2 -> mem_addr=0x1000, resp_valid in cycle 3, rdata=0xFFFF_FF80, err=0.
2. SH addr=0x2002, wdata=0x1234_ABCD, gnt delayed 3 cycles -> mem_req held stable, wstrb=1100, mem_wdata=0xABCD_ABCD, one resp_valid after gnt with rdata=0.
3. LW addr=0x0001 and SH addr=0x0003 -> no mem_req, resp_valid the cycle after accept, err=1; illegal load funct3=111 -> same.
4. LHU addr=0x0002, mem_rdata=0xF00D_0000 -> rdata=0x0000_F00D; LH with the same inputs -> 0xFFFF_F00D.
5. TIMEOUT=4, load with gnt never asserted -> mem_req high for 4 cycles, then resp_valid with err=1; a later stray mem_rvalid in IDLE is ignored.
6. rst_n low while in WAIT_R -> same cycle: busy=0, req_ready=1, no resp_valid; next load completes normally.
